// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built from two half-adder cells and a carry flop

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Bit counter is at least one bit wide so WIDTH=1 still has a legal vector.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  // Full adder on the current LSBs: two half adders, carries ORed.
  logic             ha0_sum, ha0_carry;
  logic             s_bit, ha1_carry;
  logic             c_next;
  logic [WIDTH:0]   s_cat;
  logic [WIDTH-1:0] s_sh_next;

  half_adder u_ha0 (
    .a_i     (a_sh_q[0]),
    .b_i     (b_sh_q[0]),
    .sum_o   (ha0_sum),
    .carry_o (ha0_carry)
  );

  half_adder u_ha1 (
    .a_i     (ha0_sum),
    .b_i     (c_q),
    .sum_o   (s_bit),
    .carry_o (ha1_carry)
  );

  assign c_next    = ha0_carry | ha1_carry;
  // New sum bit enters at the MSB; after WIDTH shifts the LSB sits at bit 0.
  assign s_cat     = {s_bit, s_sh_q};
  assign s_sh_next = s_cat[WIDTH:1];

  // State and datapath registers; reset clears everything, aborting any addition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // Next-state logic: load on start from IDLE or DONE, one bit per RUN cycle.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        s_sh_d = s_sh_next;
        c_d    = c_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = s_sh_next;
          carry_d = c_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial multi-bit adder built around the team's half-adder cell: two half-adder stages plus an OR form a full adder, and a carry flip-flop chains one bit per clock.
- Consumes the half adder's sum/carry pair every cycle.
- Produces a WIDTH-bit sum and carry-out with a start/done handshake.
- Sits downstream of the half-adder cell as the first sequential arithmetic stage of the design.

Parameters:
WIDTH, 8, operand width in bits (legal range 1..32).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin an addition; sampled on rising clk edge
a  input  WIDTH  operand A; captured only on an accepted start
b  input  WIDTH  operand B; captured only on an accepted start
busy  output  1  high while an addition is in progress (RUN state)
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  registered result a+b (mod 2^WIDTH)
carry  output  1  registered carry-out of a+b

Behaviour:
Reset:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- rst_n low forces immediately, independent of clk: state=IDLE, busy=0, done=0, sum=0, carry=0, shift registers=0, carry flop=0, bit counter=0.
- Reset asserted mid-operation aborts the operation. No done pulse is produced, and sum/carry read 0.

FSM states IDLE, RUN, DONE:
- IDLE: busy=0, done=0. On start=1, at that edge:
  - load a_sh<=a, b_sh<=b
  - carry flop c<=0, counter<=0
  - go to RUN
- RUN: busy=1, done=0. Each edge:
  - s = a_sh[0]^b_sh[0]^c
  - c <= (a_sh[0]&b_sh[0]) | (c&(a_sh[0]^b_sh[0]))
  - s_sh shifts right with s entering at MSB; a_sh and b_sh shift right
  - counter++
  - At the edge where counter reaches WIDTH-1 (the WIDTH-th bit edge), go to DONE. At that same edge: sum<=final s_sh value, carry<=final carry.
- DONE: busy=0, done=1 for exactly one cycle.
  - Next edge goes to RUN if start=1 (accepted as in IDLE, back-to-back); otherwise goes to IDLE.

Timing:
- Start accepted at edge E0; bits processed at edges E1..E_WIDTH.
- done=1 during the cycle after E_WIDTH. Latency from start edge to done is WIDTH+1 edges.
- Throughput is one addition per WIDTH+1 cycles.

Start, operand and output rules:
- start while in RUN is ignored. Operand changes during RUN have no effect.
- sum/carry update only at completion and hold their value until the next completion or reset. They do not change during RUN.
- Arithmetic: {carry,sum} = a + b exactly (WIDTH+1-bit result).
- Counter width: clog2(WIDTH), minimum 1 bit.
- WIDTH=1 is legal: one RUN cycle, then DONE.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with start=1 -> busy=0, done=0, sum=0, carry=0 throughout.
2. Basic add, WIDTH=8: a=8'h05, b=8'h03, start pulse -> busy=1 for 8 cycles, then done=1 for 1 cycle; sum=8'h08, carry=0; start-edge-to-done latency 9 edges.
3. Overflow and wrap-around: a=8'hFF, b=8'h01 -> sum=8'h00, carry=1. Then a=8'hFF, b=8'hFF -> sum=8'hFE, carry=1.
4. Back-to-back and ignored start:
   - start held high continuously with a=8'h10, b=8'h20 -> done pulses every 9 cycles, sum=8'h30.
   - start pulse mid-RUN with a=8'hAA -> no effect on the current result.
5. Reset mid-operation: a=8'h80, b=8'h80, drop rst_n at RUN cycle 4 -> outputs clear immediately, no done pulse. After release, a new start with a=8'h01, b=8'h01 -> sum=8'h02, carry=0.
6. Exhaustive random: WIDTH=4, all 256 (a,b) pairs -> {carry,sum} equals a+b for every pair; done pulse width is exactly 1.
